// File: rtl/fb_mem_arbiter_pkg.sv
// fb_arb_pkg: shared widths, starvation limit and return-path tag for the framebuffer arbiter
package fb_arb_pkg;
  localparam int FB_ADDR_W     = 17;
  localparam int FB_DATA_W     = 32;
  localparam int FB_BE_W       = 4;
  localparam int FB_STARVE_MAX = 8;
  typedef enum logic [1:0] {TAG_NONE, TAG_DISP, TAG_DRW_RD} tag_t;
endpackage

// File: rtl/fb_mem_arbiter_if.sv
// fb_mem_arbiter_if: draw, display and RAM signals of the framebuffer arbiter
interface fb_mem_arbiter_if
  import fb_arb_pkg::*;
#(
  parameter int ADDR_W = FB_ADDR_W,
  parameter int DATA_W = FB_DATA_W,
  parameter int BE_W   = FB_BE_W
);
  logic              drw_rts;
  logic              drw_rtr;
  logic [ADDR_W-1:0] drw_addr;
  logic [DATA_W-1:0] drw_data;
  logic [BE_W-1:0]   drw_wr_op;
  logic              bcast_xfc;
  logic [DATA_W-1:0] bcast_data;
  logic              disp_rts;
  logic              disp_rtr;
  logic [ADDR_W-1:0] disp_addr;
  logic              disp_valid;
  logic [DATA_W-1:0] disp_data;
  logic              mem_en;
  logic [BE_W-1:0]   mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  modport slave (
    input  drw_rts, drw_addr, drw_data, drw_wr_op, disp_rts, disp_addr, mem_rdata,
    output drw_rtr, bcast_xfc, bcast_data, disp_rtr, disp_valid, disp_data,
           mem_en, mem_we, mem_addr, mem_wdata
  );
  modport master (
    output drw_rts, drw_addr, drw_data, drw_wr_op, disp_rts, disp_addr, mem_rdata,
    input  drw_rtr, bcast_xfc, bcast_data, disp_rtr, disp_valid, disp_data,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/fb_mem_arbiter_grant.sv
// fb_arb_grant: display-priority grant with a starvation counter that forces a draw grant
module fb_arb_grant
  import fb_arb_pkg::*;
#(
  parameter int STARVE_MAX = FB_STARVE_MAX
) (
  input  logic clk,
  input  logic rst,
  input  logic i_drw_rts,
  input  logic i_disp_rts,
  output logic o_drw_rtr,
  output logic o_disp_rtr
);
  localparam int CW = $clog2(STARVE_MAX + 1);
  logic [CW-1:0] r_cnt;
  logic          w_force;
  assign w_force    = r_cnt == CW'(STARVE_MAX);
  assign o_disp_rtr = i_disp_rts & ~w_force;
  assign o_drw_rtr  = i_drw_rts & (~i_disp_rts | w_force);
  // Forcing blocks display grants, so the count never passes STARVE_MAX
  always_ff @(posedge clk or posedge rst)
    if (rst) r_cnt <= '0;
    else     r_cnt <= (!i_drw_rts || o_drw_rtr) ? '0 : o_disp_rtr ? r_cnt + 1'b1 : r_cnt;
endmodule

// File: rtl/fb_mem_arbiter.sv
// fb_mem_arbiter: arbitrates draw RMW and display reads onto one single-port synchronous RAM
module fb_mem_arbiter
  import fb_arb_pkg::*;
#(
  parameter int ADDR_W     = FB_ADDR_W,
  parameter int DATA_W     = FB_DATA_W,
  parameter int BE_W       = FB_BE_W,
  parameter int STARVE_MAX = FB_STARVE_MAX
) (
  input logic             clk,
  input logic             rst,
  fb_mem_arbiter_if.slave bus
);
  logic              w_drw_gnt;
  logic              w_disp_gnt;
  tag_t              w_tag;
  tag_t              r_tag1;
  tag_t              r_tag2;
  logic              r_mem_en;
  logic [BE_W-1:0]   r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_bcast_xfc;
  logic [DATA_W-1:0] r_bcast_data;
  logic              r_disp_valid;
  logic [DATA_W-1:0] r_disp_data;
  fb_arb_grant #(.STARVE_MAX(STARVE_MAX)) u_grant (
    .clk        (clk),
    .rst        (rst),
    .i_drw_rts  (bus.drw_rts),
    .i_disp_rts (bus.disp_rts),
    .o_drw_rtr  (w_drw_gnt),
    .o_disp_rtr (w_disp_gnt)
  );
  assign bus.drw_rtr    = w_drw_gnt;
  assign bus.disp_rtr   = w_disp_gnt;
  assign bus.mem_en     = r_mem_en;
  assign bus.mem_we     = r_mem_we;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_wdata  = r_mem_wdata;
  assign bus.bcast_xfc  = r_bcast_xfc;
  assign bus.bcast_data = r_bcast_data;
  assign bus.disp_valid = r_disp_valid;
  assign bus.disp_data  = r_disp_data;
  // A draw with no byte enables is a read and earns a broadcast; writes return nothing
  assign w_tag = w_disp_gnt ? TAG_DISP :
                 (w_drw_gnt && bus.drw_wr_op == '0) ? TAG_DRW_RD : TAG_NONE;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_mem_en     <= 1'b0;
      r_mem_we     <= '0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_tag1       <= TAG_NONE;
      r_tag2       <= TAG_NONE;
      r_bcast_xfc  <= 1'b0;
      r_bcast_data <= '0;
      r_disp_valid <= 1'b0;
      r_disp_data  <= '0;
    end else begin
      r_mem_en     <= w_drw_gnt | w_disp_gnt;
      r_mem_we     <= w_drw_gnt ? bus.drw_wr_op : '0;
      r_mem_addr   <= w_disp_gnt ? bus.disp_addr : w_drw_gnt ? bus.drw_addr : '0;
      r_mem_wdata  <= w_drw_gnt ? bus.drw_data : '0;
      r_tag1       <= w_tag;
      r_tag2       <= r_tag1;
      r_bcast_xfc  <= r_tag2 == TAG_DRW_RD;
      r_disp_valid <= r_tag2 == TAG_DISP;
      if (r_tag2 == TAG_DRW_RD) r_bcast_data <= bus.mem_rdata;
      if (r_tag2 == TAG_DISP)   r_disp_data  <= bus.mem_rdata;
    end
endmodule

// File: tb/tb_fb_mem_arbiter.sv
// tb_fb_mem_arbiter: scoreboard bench with a RAM model, a reference arbiter and a shadow memory
module tb_fb_mem_arbiter;
  import fb_arb_pkg::*;
  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  exp_t        exp_b[$];
  exp_t        exp_d[$];
  logic [31:0] ram    [0:(1<<17)-1];
  logic [31:0] shadow [0:(1<<17)-1];
  int          m_cnt = 0;
  logic        m_prev = 1'b0;
  fb_mem_arbiter_if bus ();
  fb_mem_arbiter dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk)
    if (bus.mem_en) begin
      bus.mem_rdata <= ram[bus.mem_addr];
      for (int i = 0; i < 4; i++)
        if (bus.mem_we[i]) ram[bus.mem_addr][8*i+:8] <= bus.mem_wdata[8*i+:8];
    end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    bus.drw_rts  = 1'b0;
    bus.disp_rts = 1'b0;
  endtask
  task automatic set_drw(input logic [16:0] a, input logic [31:0] d, input logic [3:0] op);
    bus.drw_rts   = 1'b1;
    bus.drw_addr  = a;
    bus.drw_data  = d;
    bus.drw_wr_op = op;
  endtask
  task automatic set_disp(input logic [16:0] a);
    bus.disp_rts  = 1'b1;
    bus.disp_addr = a;
  endtask
  // reference arbiter, shadow memory and return scoreboard
  initial begin
    exp_t e;
    logic dg, wg;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_b.delete();
        exp_d.delete();
        m_cnt  = 0;
        m_prev = 1'b0;
      end else begin
        dg = bus.disp_rts && m_cnt != FB_STARVE_MAX;
        wg = bus.drw_rts && (!bus.disp_rts || m_cnt == FB_STARVE_MAX);
        chk("disp_rtr", bus.disp_rtr, dg);
        chk("drw_rtr", bus.drw_rtr, wg);
        chk("mem_en", bus.mem_en, m_prev);
        if (bus.bcast_xfc) begin
          if (exp_b.size() == 0) chk("bcast_spurious", 1, 0);
          else begin
            e = exp_b.pop_front();
            chk("bcast_data", bus.bcast_data, e.data);
            chk("bcast_cycle", cyc, e.cyc);
          end
        end
        if (bus.disp_valid) begin
          if (exp_d.size() == 0) chk("disp_spurious", 1, 0);
          else begin
            e = exp_d.pop_front();
            chk("disp_data", bus.disp_data, e.data);
            chk("disp_cycle", cyc, e.cyc);
          end
        end
        if (dg) begin
          e.data = shadow[bus.disp_addr];
          e.cyc  = cyc + 3;
          exp_d.push_back(e);
        end
        if (wg) begin
          if (bus.drw_wr_op == 4'h0) begin
            e.data = shadow[bus.drw_addr];
            e.cyc  = cyc + 3;
            exp_b.push_back(e);
          end else
            for (int i = 0; i < 4; i++)
              if (bus.drw_wr_op[i]) shadow[bus.drw_addr][8*i+:8] = bus.drw_data[8*i+:8];
        end
        m_cnt  = (!bus.drw_rts || wg) ? 0 : dg ? m_cnt + 1 : m_cnt;
        m_prev = dg || wg;
      end
    end
  end
  initial begin
    idle();
    bus.drw_addr  = '0;
    bus.drw_data  = '0;
    bus.drw_wr_op = '0;
    bus.disp_addr = '0;
    repeat (2) step();
    chk("rst_bcast_xfc", bus.bcast_xfc, 0);
    chk("rst_disp_valid", bus.disp_valid, 0);
    chk("rst_mem_en", bus.mem_en, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_bcast_data", bus.bcast_data, 0);
    chk("rst_disp_data", bus.disp_data, 0);
    rst = 1'b0;
    step();
    // write then immediately read the same word
    set_drw(17'h00010, 32'hDEADBEEF, 4'hF);
    step();
    set_drw(17'h00010, 32'h0, 4'h0);
    #1 chk("rd_rtr", bus.drw_rtr, 1);
    step();
    idle();
    chk("rd_mem_en", bus.mem_en, 1);
    chk("rd_mem_addr", bus.mem_addr, 17'h00010);
    chk("rd_mem_we", bus.mem_we, 0);
    step();
    chk("rd_xfc_n2", bus.bcast_xfc, 0);
    step();
    chk("rd_xfc_n3", bus.bcast_xfc, 1);
    chk("rd_data_n3", bus.bcast_data, 32'hDEADBEEF);
    step();
    chk("rd_xfc_n4", bus.bcast_xfc, 0);
    // byte-masked write at the top address
    set_drw(17'h1FFFF, 32'h11223344, 4'hF);
    step();
    set_drw(17'h1FFFF, 32'hAABBCCDD, 4'b0101);
    step();
    set_drw(17'h1FFFF, 32'h0, 4'h0);
    step();
    idle();
    step();
    chk("bw_no_xfc", bus.bcast_xfc, 0);
    step();
    chk("bw_xfc", bus.bcast_xfc, 1);
    chk("bw_data", bus.bcast_data, 32'h11BB33DD);
    // preload display and draw regions
    for (int i = 0; i < 4; i++) begin
      step();
      set_drw(17'(i), $urandom, 4'hF);
      step();
      set_drw(17'(17'h100 + i), $urandom, 4'hF);
    end
    step();
    idle();
    step();
    // display priority, draw served next cycle
    set_disp(17'h2);
    set_drw(17'h101, 32'h0, 4'h0);
    #1 chk("pri_disp_rtr", bus.disp_rtr, 1);
    chk("pri_drw_rtr", bus.drw_rtr, 0);
    step();
    bus.disp_rts = 1'b0;
    #1 chk("pri_drw_next", bus.drw_rtr, 1);
    step();
    idle();
    step();
    // starvation: both requesting for 20 cycles
    for (int i = 0; i < 20; i++) begin
      set_disp(17'(i % 4));
      set_drw(17'(17'h100 + i % 4), 32'h0, 4'h0);
      #1 chk("starve_drw", bus.drw_rtr, (i == 8 || i == 17));
      chk("starve_one_hot", bus.drw_rtr & bus.disp_rtr, 0);
      step();
    end
    idle();
    step();
    // draw drops mid-count, count restarts
    for (int i = 0; i < 15; i++) begin
      set_disp(17'(i % 4));
      set_drw(17'h102, 32'h0, 4'h0);
      if (i == 5) bus.drw_rts = 1'b0;
      #1 chk("clr_drw", bus.drw_rtr, (i == 14));
      step();
    end
    idle();
    step();
    // back-to-back alternating display and draw reads
    for (int i = 0; i < 8; i++) begin
      idle();
      if (i % 2 == 0) set_disp(17'(i / 2));
      else set_drw(17'(17'h100 + i / 2), 32'h0, 4'h0);
      step();
    end
    idle();
    repeat (5) step();
    // reset one cycle after a draw read grant
    set_drw(17'h00010, 32'h0, 4'h0);
    step();
    idle();
    rst = 1'b1;
    #1 chk("mid_rst_xfc", bus.bcast_xfc, 0);
    chk("mid_rst_mem_en", bus.mem_en, 0);
    chk("mid_rst_bcast_data", bus.bcast_data, 0);
    chk("mid_rst_disp_data", bus.disp_data, 0);
    repeat (2) step();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("post_rst_xfc", bus.bcast_xfc, 0);
    end
    repeat (3) step();
    chk("bcast_queue_empty", exp_b.size(), 0);
    chk("disp_queue_empty", exp_d.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
